// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// The full_adder helper is the per-bit cell of the accumulator ripple chain.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

  // Returns {carry_out, sum} for one bit position.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
    logic s;
    logic c;
    s = a ^ b ^ cin;
    c = (a & b) | (cin & (a ^ b));
    return {c, s};
  endfunction

endpackage

// File: rtl/mult_acc_adder.sv
// Combinational ripple-carry adder for the multiplier accumulator (acc + mcand).
// The final carry-out is dropped: the partial product can never exceed 2*WIDTH bits.
module mult_acc_adder
  import mult_pkg::*;
#(
  parameter int WIDTH2 = 2 * MULT_WIDTH
) (
  input  logic [WIDTH2-1:0] a,
  input  logic [WIDTH2-1:0] b,
  output logic [WIDTH2-1:0] sum
);

  logic       carry;
  logic [1:0] fa;

  always_comb begin
    sum   = '0;
    carry = 1'b0;
    fa    = 2'b00;
    for (int i = 0; i < WIDTH2; i++) begin
      fa     = full_adder(a[i], b[i], carry);
      sum[i] = fa[0];
      carry  = fa[1];
    end
  end

endmodule

// File: rtl/mult_32_bit_seq.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per clock, start/busy/done handshake.
// Define MULT_EARLY_EXIT_EN to finish RUN as soon as the remaining multiplier bits are all zero.
module mult_32_bit_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   i1,
  input  logic [WIDTH-1:0]   i2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t        state_q,   state_d;
  logic [2*WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mplier_q,  mplier_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] acc_sum;
  logic               run_last;

  mult_acc_adder #(
    .WIDTH2(2 * WIDTH)
  ) u_acc_adder (
    .a  (acc_q),
    .b  (mcand_q),
    .sum(acc_sum)
  );

`ifdef MULT_EARLY_EXIT_EN
  // Once the bits still to be shifted in are zero, further cycles add nothing.
  assign run_last = (cnt_q == CNT_LAST) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign run_last = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, i1};
          mplier_d = i2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_sum;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Load the product on the way into DONE so it is valid alongside done.
        if (run_last) begin
          product_d = acc_d;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
